// File: rtl/tlk2711_axi_mem_slave.sv
// AXI4 memory responder on block RAM for the tlk2711 DMA master port.
// Read and write channels are independent FSMs, so fetches and stores overlap.
module tlk2711_axi_mem_slave #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_AW     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int S     = $clog2(NB);
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [2:0] NATIVE_SIZE = 3'(S);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Only the word-index slice of each address is decoded.
    logic unused_addr;
    assign unused_addr = ^{s_axi_araddr[ADDR_WIDTH-1:MEM_AW+S], s_axi_araddr[S-1:0],
                           s_axi_awaddr[ADDR_WIDTH-1:MEM_AW+S], s_axi_awaddr[S-1:0]};

    // ---------------------------------------------------------------- read
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    r_state_t              r_state, r_state_nxt;
    logic [ID_WIDTH-1:0]   r_id;
    logic [MEM_AW-1:0]     r_idx;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic                  r_fixed;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last_beat;
    logic                  r_fetch;
    logic                  ar_fire;
    logic                  r_fire;

    always_comb begin
        r_state_nxt   = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        s_axi_rresp   = RESP_OKAY;
        r_fetch       = 1'b0;
        r_last_beat   = (r_cnt == r_len);
        case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_state_nxt = R_FETCH;
            end
            R_FETCH: begin
                r_fetch     = 1'b1;
                r_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = r_last_beat;
                s_axi_rresp  = r_err ? RESP_SLVERR : RESP_OKAY;
                // Prefetch the next word on each accepted beat: no bubbles.
                if (s_axi_rready) begin
                    if (r_last_beat) r_state_nxt = R_IDLE;
                    else             r_fetch     = 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign ar_fire     = s_axi_arvalid && s_axi_arready;
    assign r_fire      = s_axi_rvalid && s_axi_rready;
    assign s_axi_rid   = r_id;
    assign s_axi_rdata = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_fire) begin
                r_id    <= s_axi_arid;
                r_idx   <= s_axi_araddr[MEM_AW+S-1:S];
                r_len   <= s_axi_arlen;
                r_cnt   <= '0;
                r_fixed <= (s_axi_arburst == BURST_FIXED);
                r_err   <= s_axi_arburst[1] || (s_axi_arsize != NATIVE_SIZE);
            end
            if (r_fetch) begin
                r_data <= mem[r_idx];
                if (!r_fixed) r_idx <= r_idx + MEM_AW'(1);
            end
            if (r_fire) r_cnt <= r_cnt + 8'd1;
        end
    end

    // --------------------------------------------------------------- write
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t            w_state, w_state_nxt;
    logic [ID_WIDTH-1:0] w_id;
    logic [MEM_AW-1:0]   w_idx;
    logic [7:0]          w_len;
    logic [7:0]          w_cnt;
    logic                w_fixed;
    logic                w_err;
    logic [1:0]          w_bresp;
    logic                w_at_len;
    logic                w_fire;
    logic                w_end;
    logic                aw_fire;

    always_comb begin
        w_state_nxt   = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        w_fire        = 1'b0;
        w_end         = 1'b0;
        w_at_len      = (w_cnt == w_len);
        case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                w_fire       = s_axi_wvalid;
                // Either an early wlast or reaching len closes the burst.
                w_end        = s_axi_wvalid && (s_axi_wlast || w_at_len);
                if (w_end) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = w_bresp;
                if (s_axi_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_fire   = s_axi_awvalid && s_axi_awready;
    assign s_axi_bid = w_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_err   <= 1'b0;
            w_bresp <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (aw_fire) begin
                w_id    <= s_axi_awid;
                w_idx   <= s_axi_awaddr[MEM_AW+S-1:S];
                w_len   <= s_axi_awlen;
                w_cnt   <= '0;
                w_fixed <= (s_axi_awburst == BURST_FIXED);
                w_err   <= s_axi_awburst[1] || (s_axi_awsize != NATIVE_SIZE);
            end
            if (w_fire) begin
                w_cnt <= w_cnt + 8'd1;
                if (!w_fixed) w_idx <= w_idx + MEM_AW'(1);
            end
            if (w_end)
                w_bresp <= (w_err || (s_axi_wlast != w_at_len)) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Read-first RAM: a same-edge read of this word sees the old contents.
    always_ff @(posedge clk) begin
        if (w_fire && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

endmodule
